// File: rtl/ciq_pkg.sv
// Shared constants and types for the compressed issue queue (CIQ).
// Slot addresses are 4 bits wide, so the queue depth is fixed at 16.
package ciq_pkg;

    localparam int CIQ_DEPTH  = 16;
    localparam int CIQ_AW     = 4;
    localparam int DECODE_NUM = 4;

    typedef logic [CIQ_AW-1:0] ciq_addr_t;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } ciq_state_e;

endpackage

// File: rtl/ciq_popcnt16.sv
// 16-bit population count.
// Ports: din (16 bits in), cnt (number of set bits, 0..16).
module ciq_popcnt16 (
    input  logic [15:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + 5'(din[i]);
        end
    end

endmodule

// File: rtl/ciq_dispatch_ctrl.sv
// CIQ entry bookkeeping: writes dispatch groups into finder-chosen slots,
// retires entries on issue grant, clears on flush, tracks occupancy.
// Ports: clk, rst_n (async, active-low);
//   disp_valid/disp_payload/disp_ready : dispatch group, all-or-nothing;
//   free_addr/free_valid               : nth free slot from the finder;
//   ciq_free/ent_valid/ent_payload     : registered entry state;
//   iss_grant                          : entries issued this cycle;
//   flush                              : discard all entries;
//   occ_cnt                            : occupied entry count 0..16.
module ciq_dispatch_ctrl #(
    parameter int DECODE_NUM = 4,
    parameter int CIQ_DEPTH  = 16,
    parameter int PAYLOAD_W  = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DECODE_NUM-1:0]           disp_valid,
    input  logic [DECODE_NUM*PAYLOAD_W-1:0] disp_payload,
    output logic                            disp_ready,
    input  logic [DECODE_NUM*ciq_pkg::CIQ_AW-1:0] free_addr,
    input  logic [DECODE_NUM-1:0]           free_valid,
    output logic [CIQ_DEPTH-1:0]            ciq_free,
    output logic [CIQ_DEPTH-1:0]            ent_valid,
    output logic [CIQ_DEPTH*PAYLOAD_W-1:0]  ent_payload,
    input  logic [CIQ_DEPTH-1:0]            iss_grant,
    input  logic                            flush,
    output logic [4:0]                      occ_cnt
);

    import ciq_pkg::*;

    ciq_state_e           state_q, state_d;
    logic [CIQ_DEPTH-1:0] valid_q, valid_d;
    logic [CIQ_DEPTH-1:0] wr_mask, grant_eff;
    logic [PAYLOAD_W-1:0] payload_q [CIQ_DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [CIQ_DEPTH];
    logic [4:0]           occ_q, occ_d;
    logic [4:0]           wr_cnt, gnt_cnt, vld_cnt;
    ciq_addr_t            lane_addr [DECODE_NUM];
    logic                 lanes_ok, accept, alloc_clash;

    always_comb begin
        for (int i = 0; i < DECODE_NUM; i++) begin
            lane_addr[i] = free_addr[i*CIQ_AW +: CIQ_AW];
        end
    end

    // A lane is satisfiable if it is idle or has a free slot behind it.
    always_comb begin
        lanes_ok = 1'b1;
        for (int i = 0; i < DECODE_NUM; i++) begin
            lanes_ok = lanes_ok & (~disp_valid[i] | free_valid[i]);
        end
        disp_ready = lanes_ok & ~flush & (state_q == ST_RUN);
        accept     = disp_ready & disp_valid[0];
    end

    // Write mask; alloc_clash flags a lane hitting a busy or already
    // claimed slot, which the finder must never produce.
    always_comb begin
        wr_mask     = '0;
        alloc_clash = 1'b0;
        for (int i = 0; i < DECODE_NUM; i++) begin
            if (accept && disp_valid[i]) begin
                alloc_clash = alloc_clash
                            | wr_mask[lane_addr[i]]
                            | valid_q[lane_addr[i]];
                wr_mask[lane_addr[i]] = 1'b1;
            end
        end
    end

    // Grants on free entries are dropped so they cannot skew occ_cnt.
    assign grant_eff = iss_grant & valid_q;

    ciq_popcnt16 u_pop_wr  (.din(wr_mask),   .cnt(wr_cnt));
    ciq_popcnt16 u_pop_gnt (.din(grant_eff), .cnt(gnt_cnt));
    ciq_popcnt16 u_pop_vld (.din(valid_q),   .cnt(vld_cnt));

    always_comb begin
        valid_d = (valid_q & ~grant_eff) | wr_mask;
        occ_d   = occ_q + wr_cnt - gnt_cnt;
        if (flush) begin
            valid_d = '0;
            occ_d   = '0;
        end
    end

    always_comb begin
        for (int e = 0; e < CIQ_DEPTH; e++) begin
            payload_d[e] = payload_q[e];
        end
        for (int i = 0; i < DECODE_NUM; i++) begin
            if (accept && disp_valid[i]) begin
                payload_d[lane_addr[i]] =
                    disp_payload[i*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    // RECOVER lasts one cycle unless another flush arrives.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN:     state_d = flush ? ST_RECOVER : ST_RUN;
            ST_RECOVER: state_d = flush ? ST_RECOVER : ST_RUN;
            default:    state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            valid_q <= '0;
            occ_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        payload_q <= payload_d;
    end

    always_comb begin
        for (int e = 0; e < CIQ_DEPTH; e++) begin
            ent_payload[e*PAYLOAD_W +: PAYLOAD_W] = payload_q[e];
        end
    end

    assign ciq_free  = ~valid_q;
    assign ent_valid = valid_q;
    assign occ_cnt   = occ_q;

    a_occ_match: assert property (
        @(posedge clk) disable iff (!rst_n) occ_q == vld_cnt);

    a_no_dbl_alloc: assert property (
        @(posedge clk) disable iff (!rst_n) !alloc_clash);

endmodule

// File: tb/tb_ciq_dispatch_ctrl.sv
// Self-checking bench for ciq_dispatch_ctrl: directed scenarios
// followed by a randomized run against a small occupancy model.
module tb_ciq_dispatch_ctrl;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [3:0]    disp_valid;
    logic [255:0]  disp_payload;
    logic          disp_ready;
    logic [15:0]   free_addr;
    logic [3:0]    free_valid;
    logic [15:0]   ciq_free;
    logic [15:0]   ent_valid;
    logic [1023:0] ent_payload;
    logic [15:0]   iss_grant;
    logic          flush;
    logic [4:0]    occ_cnt;

    int nchk = 0;
    int nerr = 0;

    ciq_dispatch_ctrl #(
        .DECODE_NUM(4),
        .CIQ_DEPTH(16),
        .PAYLOAD_W(64)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .disp_valid(disp_valid),
        .disp_payload(disp_payload),
        .disp_ready(disp_ready),
        .free_addr(free_addr),
        .free_valid(free_valid),
        .ciq_free(ciq_free),
        .ent_valid(ent_valid),
        .ent_payload(ent_payload),
        .iss_grant(iss_grant),
        .flush(flush),
        .occ_cnt(occ_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pay(input int tag, input int lane);
        return {32'(tag), 32'hC0DE_0000 | 32'(lane)};
    endfunction

    task automatic drive(input logic [3:0] dv, input logic [3:0] fv,
                         input logic [15:0] fa, input logic [15:0] gr,
                         input logic fl, input int tag);
        disp_valid = dv;
        free_valid = fv;
        free_addr  = fa;
        iss_grant  = gr;
        flush      = fl;
        for (int i = 0; i < 4; i++) disp_payload[i*64 +: 64] = pay(tag, i);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 0);
        #1 rst_n = 1'b0;
        tick();
        tick();
        nchk++;
        if (ciq_free !== 16'hFFFF) begin
            nerr++; $display("FAIL reset_free got=%h exp=ffff", ciq_free);
        end
        nchk++;
        if (ent_valid !== 16'h0000) begin
            nerr++; $display("FAIL reset_valid got=%h exp=0000", ent_valid);
        end
        nchk++;
        if (occ_cnt !== 5'd0) begin
            nerr++; $display("FAIL reset_occ got=%0d exp=0", occ_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL reset_ready got=%b exp=1", disp_ready);
        end
    endtask

    task automatic test_basic_dispatch();
        drive(4'hF, 4'hF, 16'h3210, 16'h0, 1'b0, 1);
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL basic_ready got=%b exp=1", disp_ready);
        end
        tick();
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 0);
        nchk++;
        if (ciq_free !== 16'hFFF0) begin
            nerr++; $display("FAIL basic_free got=%h exp=fff0", ciq_free);
        end
        nchk++;
        if (occ_cnt !== 5'd4) begin
            nerr++; $display("FAIL basic_occ got=%0d exp=4", occ_cnt);
        end
        for (int e = 0; e < 4; e++) begin
            nchk++;
            if (ent_payload[e*64 +: 64] !== pay(1, e)) begin
                nerr++;
                $display("FAIL basic_payload[%0d] got=%h exp=%h",
                         e, ent_payload[e*64 +: 64], pay(1, e));
            end
        end
    endtask

    task automatic test_near_full();
        drive(4'hF, 4'hF, 16'h7654, 16'h0, 1'b0, 2);
        tick();
        drive(4'hF, 4'hF, 16'hBA98, 16'h0, 1'b0, 3);
        tick();
        drive(4'h3, 4'h3, 16'h00DC, 16'h0, 1'b0, 4);
        tick();
        drive(4'h7, 4'h3, 16'h00FE, 16'h0, 1'b0, 9);
        nchk++;
        if (disp_ready !== 1'b0) begin
            nerr++; $display("FAIL partial_ready got=%b exp=0", disp_ready);
        end
        tick();
        nchk++;
        if (occ_cnt !== 5'd14) begin
            nerr++; $display("FAIL partial_occ got=%0d exp=14", occ_cnt);
        end
        nchk++;
        if (ciq_free !== 16'hC000) begin
            nerr++; $display("FAIL partial_free got=%h exp=c000", ciq_free);
        end
        drive(4'h3, 4'h3, 16'h00FE, 16'h0, 1'b0, 10);
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL retry_ready got=%b exp=1", disp_ready);
        end
        tick();
        nchk++;
        if (occ_cnt !== 5'd16) begin
            nerr++; $display("FAIL full_occ got=%0d exp=16", occ_cnt);
        end
        nchk++;
        if (ciq_free !== 16'h0000) begin
            nerr++; $display("FAIL full_free got=%h exp=0000", ciq_free);
        end
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 0);
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL empty_group_ready got=%b exp=1", disp_ready);
        end
        drive(4'h1, 4'h0, 16'h0, 16'h0, 1'b0, 0);
        nchk++;
        if (disp_ready !== 1'b0) begin
            nerr++; $display("FAIL full_ready got=%b exp=0", disp_ready);
        end
    endtask

    task automatic test_grant_full();
        drive(4'h1, 4'h0, 16'h0, 16'h0020, 1'b0, 11);
        nchk++;
        if (disp_ready !== 1'b0) begin
            nerr++; $display("FAIL gfull_ready got=%b exp=0", disp_ready);
        end
        tick();
        nchk++;
        if (ciq_free !== 16'h0020) begin
            nerr++; $display("FAIL gfull_free got=%h exp=0020", ciq_free);
        end
        nchk++;
        if (occ_cnt !== 5'd15) begin
            nerr++; $display("FAIL gfull_occ got=%0d exp=15", occ_cnt);
        end
        drive(4'h1, 4'h1, 16'h0005, 16'h0, 1'b0, 5);
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL reuse_ready got=%b exp=1", disp_ready);
        end
        tick();
        nchk++;
        if (ciq_free !== 16'h0000 || occ_cnt !== 5'd16) begin
            nerr++;
            $display("FAIL reuse_state got free=%h occ=%0d exp free=0000 occ=16",
                     ciq_free, occ_cnt);
        end
        nchk++;
        if (ent_payload[5*64 +: 64] !== pay(5, 0)) begin
            nerr++;
            $display("FAIL reuse_payload got=%h exp=%h",
                     ent_payload[5*64 +: 64], pay(5, 0));
        end
    endtask

    task automatic test_flush();
        drive(4'h0, 4'h0, 16'h0, 16'hFE00, 1'b0, 0);
        tick();
        nchk++;
        if (occ_cnt !== 5'd9 || ciq_free !== 16'hFE00) begin
            nerr++;
            $display("FAIL preflush got free=%h occ=%0d exp free=fe00 occ=9",
                     ciq_free, occ_cnt);
        end
        drive(4'h3, 4'h3, 16'h00A9, 16'h0, 1'b1, 12);
        nchk++;
        if (disp_ready !== 1'b0) begin
            nerr++; $display("FAIL flush_ready got=%b exp=0", disp_ready);
        end
        tick();
        drive(4'h3, 4'h3, 16'h0010, 16'h0, 1'b0, 13);
        nchk++;
        if (occ_cnt !== 5'd0 || ciq_free !== 16'hFFFF) begin
            nerr++;
            $display("FAIL flush_state got free=%h occ=%0d exp free=ffff occ=0",
                     ciq_free, occ_cnt);
        end
        nchk++;
        if (disp_ready !== 1'b0) begin
            nerr++; $display("FAIL recover_ready got=%b exp=0", disp_ready);
        end
        tick();
        nchk++;
        if (occ_cnt !== 5'd0 || ciq_free !== 16'hFFFF) begin
            nerr++;
            $display("FAIL recover_nowrite got free=%h occ=%0d exp free=ffff occ=0",
                     ciq_free, occ_cnt);
        end
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL postrecover_ready got=%b exp=1", disp_ready);
        end
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b1, 0);
        tick();
        tick();
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 0);
        nchk++;
        if (disp_ready !== 1'b0) begin
            nerr++; $display("FAIL reflush_ready got=%b exp=0", disp_ready);
        end
        tick();
        nchk++;
        if (disp_ready !== 1'b1) begin
            nerr++; $display("FAIL reflush_exit got=%b exp=1", disp_ready);
        end
    endtask

    task automatic test_phantom_grant();
        drive(4'h7, 4'h7, 16'h0210, 16'h0, 1'b0, 6);
        tick();
        drive(4'h0, 4'h0, 16'h0, 16'h0084, 1'b0, 0);
        tick();
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 0);
        nchk++;
        if (occ_cnt !== 5'd2) begin
            nerr++; $display("FAIL phantom_occ got=%0d exp=2", occ_cnt);
        end
        nchk++;
        if (ciq_free !== 16'hFFFC) begin
            nerr++; $display("FAIL phantom_free got=%h exp=fffc", ciq_free);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        nchk++;
        if (ciq_free !== 16'hFFFF || occ_cnt !== 5'd0) begin
            nerr++;
            $display("FAIL async_reset got free=%h occ=%0d exp free=ffff occ=0",
                     ciq_free, occ_cnt);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] mval;
        logic        mrec;
        logic [3:0]  dv, fv;
        logic [15:0] fa, gr;
        logic        fl, exp_rdy;
        int          n, k;
        mval = '0;
        mrec = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n  = $urandom_range(0, 4);
            dv = 4'((1 << n) - 1);
            fa = '0;
            fv = '0;
            k  = 0;
            for (int e = 0; e < 16; e++) begin
                if (!mval[e] && k < 4) begin
                    fa[k*4 +: 4] = 4'(e);
                    fv[k] = 1'b1;
                    k++;
                end
            end
            gr = 16'($urandom) & 16'($urandom) & 16'($urandom);
            fl = ($urandom_range(0, 39) == 0);
            exp_rdy = !mrec && !fl && ((dv & ~fv) == 4'h0);
            drive(dv, fv, fa, gr, fl, 100 + cyc);
            nchk++;
            if (disp_ready !== exp_rdy) begin
                nerr++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b",
                         cyc, disp_ready, exp_rdy);
            end
            tick();
            if (fl) begin
                mval = '0;
                mrec = 1'b1;
            end else begin
                mrec = 1'b0;
                mval = mval & ~gr;
                if (exp_rdy && dv[0]) begin
                    for (int i = 0; i < 4; i++)
                        if (dv[i]) mval[fa[i*4 +: 4]] = 1'b1;
                end
            end
            nchk++;
            if (ciq_free !== ~mval ||
                occ_cnt !== 5'($countones(mval))) begin
                nerr++;
                $display("FAIL rand_state cyc=%0d got free=%h occ=%0d exp free=%h occ=%0d",
                         cyc, ciq_free, occ_cnt, ~mval, $countones(mval));
            end
        end
        drive(4'h0, 4'h0, 16'h0, 16'h0, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_dispatch();
        test_near_full();
        test_grant_full();
        test_flush();
        test_phantom_grant();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
